cpu_run_monitor: RTL and testbench

- Observation-side companion to the CPU top level. Watches the fetch stream and decides when a benchmark has finished.
- Finished means the program has parked on the LEGv8 branch-to-self idiom (B #0, encoding 32'h1400_0000).
- Reports halted, timeout, cycle count and instruction count, so a bench can stop on a done flag instead of a fixed cycle budget.
- Sits beside the cpu instance; it only reads fetch-stage signals and never drives the CPU.

---
 rtl/cpu_run_monitor.sv | 101 ++++++++++
 tb/tb_cpu_run_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - watches the fetch stream and flags benchmark completion
// Declares HALTED on a repeated branch-to-self at one PC, or TIMEOUT after a cycle budget.
module cpu_run_monitor #(
   parameter int PC_WIDTH    = 64,
   parameter int CNT_WIDTH   = 32,
   parameter int HALT_REPEAT = 4,
   parameter int TIMEOUT     = 1500
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fetch_valid,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic [31:0]          instr,
   output logic                 halted,
   output logic                 timed_out,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count,
   output logic [PC_WIDTH-1:0]  halt_pc
);

   localparam logic [31:0]          B_SELF  = 32'h1400_0000;
   localparam int                   RW      = $clog2(HALT_REPEAT + 1);
   localparam logic [RW-1:0]        RPT_MAX = RW'(HALT_REPEAT);
   localparam logic [CNT_WIDTH-1:0] TO_VAL  = CNT_WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTED  = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   state_t                state, state_n;
   logic [RW-1:0]         rpt, rpt_n;
   logic [PC_WIDTH-1:0]   last_pc, last_pc_n;
   logic [CNT_WIDTH-1:0]  cyc_n, ins_n;
   logic [PC_WIDTH-1:0]   hpc_n;
   logic                  match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         rpt         <= '0;
         last_pc     <= '0;
         cycle_count <= '0;
         instr_count <= '0;
         halt_pc     <= '0;
      end else begin
         state       <= state_n;
         rpt         <= rpt_n;
         last_pc     <= last_pc_n;
         cycle_count <= cyc_n;
         instr_count <= ins_n;
         halt_pc     <= hpc_n;
      end
   end

   always_comb begin
      state_n   = state;
      rpt_n     = rpt;
      last_pc_n = last_pc;
      cyc_n     = cycle_count;
      ins_n     = instr_count;
      hpc_n     = halt_pc;
      match     = fetch_valid && (instr == B_SELF);

      if (state == ST_RUN) begin
         cyc_n = cycle_count + 1'b1;
         if (fetch_valid) begin
            ins_n = instr_count + 1'b1;
         end

         // Stalled cycles leave the streak untouched; only a real non-match fetch breaks it.
         if (match) begin
            last_pc_n = pc;
            if ((rpt == '0) || (pc == last_pc)) begin
               if (rpt != RPT_MAX) begin
                  rpt_n = rpt + 1'b1;
               end
            end else begin
               rpt_n = RW'(1);
            end
         end else if (fetch_valid) begin
            rpt_n = '0;
         end

         // Halt takes priority when both complete on the same edge.
         if (rpt_n == RPT_MAX) begin
            state_n = ST_HALTED;
            hpc_n   = pc;
         end else if (cyc_n == TO_VAL) begin
            state_n = ST_TIMEOUT;
         end
      end
   end

   assign halted    = (state == ST_HALTED);
   assign timed_out = (state == ST_TIMEOUT);
   assign done      = halted || timed_out;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - self-checking bench for cpu_run_monitor
// Reference model works from the list of valid fetches seen since reset.
module tb_cpu_run_monitor;

   localparam int          HR     = 4;
   localparam int          TO     = 20;
   localparam logic [31:0] B_SELF = 32'h1400_0000;
   localparam logic [31:0] ADD    = 32'h8B02_0020;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [63:0] pc = '0;
   logic [31:0] instr = '0;
   logic        halted, timed_out, done;
   logic [31:0] cycle_count, instr_count;
   logic [63:0] halt_pc;

   cpu_run_monitor #(
      .PC_WIDTH(64), .CNT_WIDTH(32), .HALT_REPEAT(HR), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .pc(pc), .instr(instr),
      .halted(halted), .timed_out(timed_out), .done(done),
      .cycle_count(cycle_count), .instr_count(instr_count), .halt_pc(halt_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_bself;
      logic [63:0] addr;
   } fetch_t;

   // model state: 0 run, 1 halted, 2 timeout
   int          m_state;
   int          m_cyc, m_ins;
   logic [63:0] m_hpc;
   fetch_t      hist[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cyc = 0; m_ins = 0; m_hpc = '0;
      hist.delete();
   endtask

   // Halted when the last HR valid fetches are all branch-to-self at a single address.
   function automatic bit streak_done();
      if (hist.size() < HR) return 0;
      for (int i = hist.size() - HR; i < hist.size(); i++) begin
         if (!hist[i].is_bself || hist[i].addr != hist[hist.size()-1].addr) return 0;
      end
      return 1;
   endfunction

   task automatic model_edge(input logic fv, input logic [63:0] p, input logic [31:0] ins);
      fetch_t f;
      if (reset || m_state != 0) return;
      m_cyc++;
      if (fv) begin
         m_ins++;
         f.is_bself = (ins == B_SELF);
         f.addr     = p;
         hist.push_back(f);
      end
      if (streak_done()) begin
         m_state = 1;
         m_hpc   = p;
      end else if (m_cyc == TO) begin
         m_state = 2;
      end
   endtask

   always @(negedge clk) begin
      chk("halted",      {63'd0, halted},    {63'd0, m_state == 1});
      chk("timed_out",   {63'd0, timed_out}, {63'd0, m_state == 2});
      chk("done",        {63'd0, done},      {63'd0, m_state != 0});
      chk("cycle_count", {32'd0, cycle_count}, 64'(m_cyc));
      chk("instr_count", {32'd0, instr_count}, 64'(m_ins));
      chk("halt_pc",     halt_pc, m_hpc);
   end

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic fv, input logic [63:0] p, input logic [31:0] ins);
      fetch_valid = fv; pc = p; instr = ins;
      @(posedge clk);
      model_edge(fv, p, ins);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      fetch_valid = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rand_cycles(input int n);
      logic [63:0] p;
      p = 64'h100;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(4, 0) == 0) p = 64'h100 + 64'($urandom_range(2, 0)) * 4;
         step($urandom_range(4, 0) != 0, p, ($urandom_range(9, 0) < 6) ? B_SELF : $urandom);
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // idle cycles, then an asynchronous reset in mid-cycle
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
      chk("lit_idle_cycles", {32'd0, cycle_count}, 64'd3);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("lit_async_cycles", {32'd0, cycle_count}, 64'd0);
      chk("lit_async_done",   {63'd0, done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // straight-line code then a parked loop at 0x28
      for (int i = 0; i < 10; i++) step(1'b1, 64'(i * 4), ADD);
      for (int i = 0; i < 4; i++) begin
         chk("lit_not_halted_yet", {63'd0, halted}, 64'd0);
         step(1'b1, 64'h28, B_SELF);
      end
      chk("lit_halted",  {63'd0, halted}, 64'd1);
      chk("lit_hpc_28",  halt_pc, 64'h28);
      chk("lit_instr14", {32'd0, instr_count}, 64'd14);
      chk("lit_cyc14",   {32'd0, cycle_count}, 64'd14);
      rand_cycles(20);
      chk("lit_frozen_cyc", {32'd0, cycle_count}, 64'd14);

      // stall inside the streak
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 64'h40, B_SELF);
      step(1'b0, 64'h40, B_SELF);
      chk("lit_stall_not_halted", {63'd0, halted}, 64'd0);
      step(1'b1, 64'h40, B_SELF);
      chk("lit_stall_halted", {63'd0, halted}, 64'd1);
      chk("lit_stall_instr",  {32'd0, instr_count}, 64'd4);

      // streak restarts when the address moves
      do_reset();
      step(1'b1, 64'h40, B_SELF);
      step(1'b1, 64'h40, B_SELF);
      for (int i = 0; i < 3; i++) step(1'b1, 64'h44, B_SELF);
      chk("lit_move_not_halted", {63'd0, halted}, 64'd0);
      step(1'b1, 64'h44, B_SELF);
      chk("lit_move_halted", {63'd0, halted}, 64'd1);
      chk("lit_hpc_44",      halt_pc, 64'h44);

      // timeout
      do_reset();
      for (int i = 0; i < TO; i++) step(1'b1, 64'(i * 4), ADD);
      chk("lit_to_flag",  {63'd0, timed_out}, 64'd1);
      chk("lit_to_cyc",   {32'd0, cycle_count}, 64'd20);
      chk("lit_to_instr", {32'd0, instr_count}, 64'd20);
      chk("lit_to_halt",  {63'd0, halted}, 64'd0);
      rand_cycles(5);

      // halt completing on the timeout edge
      do_reset();
      for (int i = 0; i < TO - HR; i++) step(1'b1, 64'(i * 4), ADD);
      for (int i = 0; i < HR; i++) step(1'b1, 64'h50, B_SELF);
      chk("lit_tie_halted", {63'd0, halted}, 64'd1);
      chk("lit_tie_to",     {63'd0, timed_out}, 64'd0);
      chk("lit_tie_cyc",    {32'd0, cycle_count}, 64'd20);
      do_reset();
      chk("lit_rst_cyc",  {32'd0, cycle_count}, 64'd0);
      chk("lit_rst_done", {63'd0, done}, 64'd0);

      // randomized runs
      for (int r = 0; r < 12; r++) begin
         do_reset();
         rand_cycles(30);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
